// File: rtl/imem_program_loader.sv
// Boot loader: packs a byte stream big-endian into 32-bit words, writes them
// to instruction memory and holds the datapath in reset until the load completes.
module imem_program_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_COUNT = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(WORD_COUNT);

  state_t                state;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] next_idx;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] packed_w;
  logic                  len_ok;
  logic                  take;

  assign len_ok   = (load_len != '0) && ({1'b0, load_len} <= MAX_LEN);
  assign take     = byte_valid && byte_ready;
  assign next_idx = word_idx + ADDR_WIDTH'(1);
  assign packed_w = {shift_q[DATA_WIDTH-9:0], byte_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_idx   <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_reset  <= 1'b1;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (load_start) begin
            done      <= 1'b0;
            cpu_reset <= 1'b1;
            if (len_ok) begin
              state      <= RECV;
              len_q      <= load_len;
              word_idx   <= '0;
              byte_cnt   <= '0;
              shift_q    <= '0;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              error      <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        RECV: begin
          if (take) begin
            shift_q <= packed_w;
            if (byte_cnt == 2'd3) begin
              // Word complete: present it to memory next cycle.
              byte_cnt   <= '0;
              state      <= WRITE;
              imem_we    <= 1'b1;
              imem_addr  <= word_idx;
              imem_wdata <= packed_w;
              byte_ready <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          word_idx <= next_idx;
          if (next_idx == len_q) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
